// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the instruction/data memory arbiter.
package mem_pkg;

  localparam int INST_WIDTH = 18;
  localparam int DATA_WIDTH = 2 * INST_WIDTH;

  // IDLE accepts new work; the *_HI states run the second beat of a data access.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DM_RD_HI = 2'd1,
    DM_WR_HI = 2'd2
  } state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a registered read port (read-before-write).
module sp_ram #(
  parameter int    WIDTH     = 18,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // One access per cycle: optional write plus a registered read of the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serves the fetch port and the 36-bit data port from one 18-bit single-port RAM.
// Data accesses take two beats (low word at the even address, then high word);
// data always wins over fetch when both ask in the same cycle.
module mem_arbiter #(
  parameter int    INST_WIDTH    = mem_pkg::INST_WIDTH,
  parameter int    DATA_WIDTH    = mem_pkg::DATA_WIDTH,
  parameter int    DEPTH         = 1024,
  parameter int    ADDR_WIDTH    = 18,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_ready,
  output logic                  o_if_valid,
  output logic [INST_WIDTH-1:0] o_if_instruction,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  output logic                  o_dm_ready,
  output logic                  o_dm_valid,
  output logic [DATA_WIDTH-1:0] o_dm_rdata,
  output logic                  o_dm_err
);

  import mem_pkg::*;

  localparam int IW = $clog2(DEPTH);

  state_t                state;
  logic [IW-1:0]         addr_q;
  logic [INST_WIDTH-1:0] wdata_hi_q;
  logic                  err_q;
  logic [INST_WIDTH-1:0] lo_q;
  logic [INST_WIDTH-1:0] inst_hold_q;
  logic [DATA_WIDTH-1:0] rdata_hold_q;
  logic                  if_valid_q;
  logic                  dm_valid_q;
  logic                  dm_err_q;
  logic                  dm_load_q;

  logic [IW-1:0]         ram_addr;
  logic                  ram_we;
  logic [INST_WIDTH-1:0] ram_wdata;
  logic [INST_WIDTH-1:0] ram_rdata;

  logic                  dm_accept;
  logic                  if_accept;
  logic [IW-1:0]         dm_idx;
  logic [IW-1:0]         dm_even;
  logic                  misaligned;
  logic                  unused_addr_bits;

  assign dm_idx     = i_dm_addr[IW-1:0];
  assign dm_even    = {dm_idx[IW-1:1], 1'b0};
  assign misaligned = dm_idx[0];

  assign o_dm_ready = (state == IDLE) && !i_rst;
  assign o_if_ready = (state == IDLE) && !i_dm_req && !i_rst;
  assign dm_accept  = i_dm_req && o_dm_ready;
  assign if_accept  = i_if_req && o_if_ready;

  assign unused_addr_bits = ^{i_if_addr[ADDR_WIDTH-1:IW], i_dm_addr[ADDR_WIDTH-1:IW]};

  // Response data comes straight from the RAM read register in the response
  // cycle, and from a hold register afterwards so it stays stable.
  assign o_if_valid       = if_valid_q;
  assign o_if_instruction = if_valid_q ? ram_rdata : inst_hold_q;
  assign o_dm_valid       = dm_valid_q;
  assign o_dm_err         = dm_err_q;
  assign o_dm_rdata       = (dm_valid_q && dm_load_q) ? {ram_rdata, lo_q} : rdata_hold_q;

  sp_ram #(
    .WIDTH    (INST_WIDTH),
    .DEPTH    (DEPTH),
    .INIT_FILE(MEM_INIT_FILE)
  ) u_ram (
    .clk  (i_clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // RAM port mux: first data beat or fetch in IDLE, second data beat otherwise.
  // Misaligned stores and a reset during the high beat suppress the write.
  always_comb begin
    ram_addr  = i_if_addr[IW-1:0];
    ram_we    = 1'b0;
    ram_wdata = i_dm_wdata[INST_WIDTH-1:0];
    case (state)
      IDLE: begin
        if (dm_accept) begin
          ram_addr = dm_even;
          ram_we   = i_dm_we && !misaligned;
        end
      end
      DM_RD_HI: begin
        ram_addr = addr_q + IW'(1);
      end
      DM_WR_HI: begin
        ram_addr  = addr_q + IW'(1);
        ram_wdata = wdata_hi_q;
        ram_we    = !err_q && !i_rst;
      end
      default: ;
    endcase
  end

  // Capture the data request payload at accept and the low load word after beat one.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && dm_accept) begin
      addr_q     <= dm_even;
      err_q      <= misaligned;
      wdata_hi_q <= i_dm_wdata[DATA_WIDTH-1:INST_WIDTH];
    end
    if (state == DM_RD_HI) begin
      lo_q <= ram_rdata;
    end
  end

  // Control FSM with registered response pulses and output hold registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      dm_err_q     <= 1'b0;
      dm_load_q    <= 1'b0;
      inst_hold_q  <= '0;
      rdata_hold_q <= '0;
    end else begin
      if_valid_q <= if_accept;
      dm_valid_q <= 1'b0;
      dm_err_q   <= 1'b0;
      if (if_valid_q) begin
        inst_hold_q <= ram_rdata;
      end
      if (dm_valid_q && dm_load_q) begin
        rdata_hold_q <= {ram_rdata, lo_q};
      end
      case (state)
        IDLE: begin
          if (dm_accept) begin
            state <= i_dm_we ? DM_WR_HI : DM_RD_HI;
          end
        end
        DM_RD_HI: begin
          state      <= IDLE;
          dm_valid_q <= 1'b1;
          dm_err_q   <= err_q;
          dm_load_q  <= 1'b1;
        end
        DM_WR_HI: begin
          state      <= IDLE;
          dm_valid_q <= 1'b1;
          dm_err_q   <= err_q;
          dm_load_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle table, directed corner
// sequences, and randomized traffic against a transaction-level memory model.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [17:0] i_if_addr;
  logic        o_if_ready;
  logic        o_if_valid;
  logic [17:0] o_if_instruction;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [17:0] i_dm_addr;
  logic [35:0] i_dm_wdata;
  logic        o_dm_ready;
  logic        o_dm_valid;
  logic [35:0] o_dm_rdata;
  logic        o_dm_err;

  int nChecks = 0;
  int nFail   = 0;

  logic [35:0] heldRdata;
  logic [17:0] heldInstr;
  logic [17:0] mdl [1024];

  typedef struct {
    logic        if_req;
    logic [17:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [17:0] dm_addr;
    logic [35:0] dm_wdata;
    logic        e_if_ready;
    logic        e_dm_ready;
    logic        e_if_valid;
    logic [17:0] e_instr;
    logic        e_dm_valid;
    logic [35:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [19];

  localparam logic [35:0] W6 = {18'h3ABCD, 18'h01234};
  localparam logic [35:0] W4 = {18'h15555, 18'h2AAAA};
  localparam logic [35:0] ONES = 36'hFFFFFFFFF;

  mem_arbiter #(
    .INST_WIDTH   (18),
    .DATA_WIDTH   (36),
    .DEPTH        (1024),
    .ADDR_WIDTH   (18),
    .MEM_INIT_FILE("")
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_if_req        (i_if_req),
    .i_if_addr       (i_if_addr),
    .o_if_ready      (o_if_ready),
    .o_if_valid      (o_if_valid),
    .o_if_instruction(o_if_instruction),
    .i_dm_req        (i_dm_req),
    .i_dm_we         (i_dm_we),
    .i_dm_addr       (i_dm_addr),
    .i_dm_wdata      (i_dm_wdata),
    .o_dm_ready      (o_dm_ready),
    .o_dm_valid      (o_dm_valid),
    .o_dm_rdata      (o_dm_rdata),
    .o_dm_err        (o_dm_err)
  );

  // Free-running 10 ns clock.
  always #5 i_clk = ~i_clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [17:0] ifAddr,
                               input logic dmReq, input logic dmWe,
                               input logic [17:0] dmAddr, input logic [35:0] dmWdata);
    i_if_req   = ifReq;
    i_if_addr  = ifAddr;
    i_dm_req   = dmReq;
    i_dm_we    = dmWe;
    i_dm_addr  = dmAddr;
    i_dm_wdata = dmWdata;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic eIfR, input logic eDmR, input logic eIfV,
                          input logic [17:0] eI, input logic eDmV, input logic [35:0] eR, input logic eErr);
    checkOutput({tag, ".if_ready"}, 36'(o_if_ready), 36'(eIfR));
    checkOutput({tag, ".dm_ready"}, 36'(o_dm_ready), 36'(eDmR));
    checkOutput({tag, ".if_valid"}, 36'(o_if_valid), 36'(eIfV));
    checkOutput({tag, ".instr"}, 36'(o_if_instruction), 36'(eI));
    checkOutput({tag, ".dm_valid"}, 36'(o_dm_valid), 36'(eDmV));
    checkOutput({tag, ".rdata"}, o_dm_rdata, eR);
    checkOutput({tag, ".err"}, 36'(o_dm_err), 36'(eErr));
  endtask

  // Full data access: request, busy beat, response check; ends one cycle later.
  task automatic dataOp(input string tag, input logic we, input logic [17:0] addr,
                        input logic [35:0] wdata, input logic [35:0] expLoad, input logic expErr);
    applyStimulus(1'b0, 18'd0, 1'b1, we, addr, wdata);
    checkOutput({tag, ".accept"}, 36'(o_dm_ready), 36'd1);
    tick();
    applyStimulus(1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'd0);
    checkOutput({tag, ".busy"}, 36'(o_dm_ready), 36'd0);
    tick();
    applyStimulus(1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'd0);
    if (!we) heldRdata = expLoad;
    checkOutput({tag, ".valid"}, 36'(o_dm_valid), 36'd1);
    checkOutput({tag, ".err"}, 36'(o_dm_err), 36'(expErr));
    checkOutput({tag, ".rdata"}, o_dm_rdata, heldRdata);
    tick();
  endtask

  // Single fetch: accept, then check the one-cycle response.
  task automatic fetchOp(input string tag, input logic [17:0] addr, input logic [17:0] expInstr);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 18'd0, 36'd0);
    checkOutput({tag, ".accept"}, 36'(o_if_ready), 36'd1);
    tick();
    applyStimulus(1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'd0);
    checkOutput({tag, ".valid"}, 36'(o_if_valid), 36'd1);
    checkOutput({tag, ".instr"}, 36'(o_if_instruction), 36'(expInstr));
    heldInstr = expInstr;
    tick();
  endtask

  // Main test sequence.
  initial begin
    logic        dmReq, dmWe, ifReq;
    logic [17:0] dmAddr, ifAddr;
    logic [35:0] dmW;
    int          busy, dmDue, hi, lo, a;
    bit          ifV, dmPend, dmErrE, dmLoadE, expDmV;
    logic [17:0] ifI, expI;
    logic [35:0] dmDataE, expR;

    // Cycle table: inputs for the cycle and the outputs expected in that cycle.
    vecs[0]  = '{1'b0, 18'd0, 1'b1, 1'b1, 18'd6, W6,    1'b0, 1'b1, 1'b0, 18'h0,     1'b0, 36'h0, 1'b0};
    vecs[1]  = '{1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'h0, 1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 36'h0, 1'b0};
    vecs[2]  = '{1'b0, 18'd0, 1'b1, 1'b1, 18'd4, W4,    1'b0, 1'b1, 1'b0, 18'h0,     1'b1, 36'h0, 1'b0};
    vecs[3]  = '{1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'h0, 1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 36'h0, 1'b0};
    vecs[4]  = '{1'b1, 18'd4, 1'b0, 1'b0, 18'd0, 36'h0, 1'b1, 1'b1, 1'b0, 18'h0,     1'b1, 36'h0, 1'b0};
    vecs[5]  = '{1'b1, 18'd5, 1'b0, 1'b0, 18'd0, 36'h0, 1'b1, 1'b1, 1'b1, 18'h2AAAA, 1'b0, 36'h0, 1'b0};
    vecs[6]  = '{1'b1, 18'd6, 1'b0, 1'b0, 18'd0, 36'h0, 1'b1, 1'b1, 1'b1, 18'h15555, 1'b0, 36'h0, 1'b0};
    vecs[7]  = '{1'b1, 18'd7, 1'b1, 1'b0, 18'd4, 36'h0, 1'b0, 1'b1, 1'b1, 18'h01234, 1'b0, 36'h0, 1'b0};
    vecs[8]  = '{1'b1, 18'd7, 1'b0, 1'b0, 18'd0, 36'h0, 1'b0, 1'b0, 1'b0, 18'h01234, 1'b0, 36'h0, 1'b0};
    vecs[9]  = '{1'b1, 18'd7, 1'b0, 1'b0, 18'd0, 36'h0, 1'b1, 1'b1, 1'b0, 18'h01234, 1'b1, W4,    1'b0};
    vecs[10] = '{1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'h0, 1'b1, 1'b1, 1'b1, 18'h3ABCD, 1'b0, W4,    1'b0};
    vecs[11] = '{1'b0, 18'd0, 1'b1, 1'b1, 18'd7, ONES,  1'b0, 1'b1, 1'b0, 18'h3ABCD, 1'b0, W4,    1'b0};
    vecs[12] = '{1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'h0, 1'b0, 1'b0, 1'b0, 18'h3ABCD, 1'b0, W4,    1'b0};
    vecs[13] = '{1'b0, 18'd0, 1'b1, 1'b0, 18'd6, 36'h0, 1'b0, 1'b1, 1'b0, 18'h3ABCD, 1'b1, W4,    1'b1};
    vecs[14] = '{1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'h0, 1'b0, 1'b0, 1'b0, 18'h3ABCD, 1'b0, W4,    1'b0};
    vecs[15] = '{1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'h0, 1'b1, 1'b1, 1'b0, 18'h3ABCD, 1'b1, W6,    1'b0};
    vecs[16] = '{1'b0, 18'd0, 1'b1, 1'b0, 18'd5, 36'h0, 1'b0, 1'b1, 1'b0, 18'h3ABCD, 1'b0, W6,    1'b0};
    vecs[17] = '{1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'h0, 1'b0, 1'b0, 1'b0, 18'h3ABCD, 1'b0, W6,    1'b0};
    vecs[18] = '{1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'h0, 1'b1, 1'b1, 1'b0, 18'h3ABCD, 1'b1, W4,    1'b1};

    i_rst = 1'b1;
    applyStimulus(1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'd0);
    tick();
    tick();
    checkAll("reset", 1'b0, 1'b0, 1'b0, 18'h0, 1'b0, 36'h0, 1'b0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].if_req, vecs[i].if_addr, vecs[i].dm_req, vecs[i].dm_we,
                    vecs[i].dm_addr, vecs[i].dm_wdata);
      checkAll($sformatf("row%0d", i), vecs[i].e_if_ready, vecs[i].e_dm_ready, vecs[i].e_if_valid,
               vecs[i].e_instr, vecs[i].e_dm_valid, vecs[i].e_rdata, vecs[i].e_err);
      tick();
    end
    heldRdata = W4;
    heldInstr = 18'h3ABCD;

    // Store/load round trip and the split of the halves across two words.
    dataOp("st10", 1'b1, 18'd10, 36'h123456789, 36'h0, 1'b0);
    fetchOp("rd10", 18'd10, 18'h16789);
    fetchOp("rd11", 18'd11, 18'h048D1);
    dataOp("ld10", 1'b0, 18'd10, 36'h0, 36'h123456789, 1'b0);

    // Top-of-memory store and address wrap through the ignored upper bits.
    dataOp("st2", 1'b1, 18'd2, {18'h0C0C1, 18'h0D0D2}, 36'h0, 1'b0);
    dataOp("st1022", 1'b1, 18'd1022, {18'h2FEDC, 18'h10203}, 36'h0, 1'b0);
    fetchOp("rd1023", 18'h3FFFF, 18'h2FEDC);
    dataOp("ld1026", 1'b0, 18'h00402, 36'h0, {18'h0C0C1, 18'h0D0D2}, 1'b0);
    dataOp("ld1022", 1'b0, 18'd1022, 36'h0, {18'h2FEDC, 18'h10203}, 1'b0);

    // Reset during the high beat of a store.
    dataOp("st20", 1'b1, 18'd20, {18'h00AAA, 18'h00BBB}, 36'h0, 1'b0);
    applyStimulus(1'b0, 18'd0, 1'b1, 1'b1, 18'd20, {18'h11111, 18'h22222});
    checkOutput("rstwr.accept", 36'(o_dm_ready), 36'd1);
    tick();
    i_rst = 1'b1;
    applyStimulus(1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'd0);
    tick();
    i_rst = 1'b0;
    applyStimulus(1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 36'd0);
    checkAll("rstwr.after", 1'b1, 1'b1, 1'b0, 18'h0, 1'b0, 36'h0, 1'b0);
    tick();
    checkOutput("rstwr.noack", 36'(o_dm_valid), 36'd0);
    heldRdata = 36'h0;
    heldInstr = 18'h0;
    dataOp("ld20", 1'b0, 18'd20, 36'h0, {18'h00AAA, 18'h22222}, 1'b0);

    // Fill words 0..63 so the random phase reads only known contents.
    for (int i = 0; i < 32; i++) begin
      dmW = {4'($urandom), 32'($urandom)};
      mdl[2*i]   = dmW[17:0];
      mdl[2*i+1] = dmW[35:18];
      dataOp($sformatf("fill%0d", i), 1'b1, 18'(2*i), dmW, 36'h0, 1'b0);
    end

    // Random traffic; the model works on whole transactions and their due cycles.
    dmReq = 1'b0; dmWe = 1'b0; dmAddr = '0; dmW = '0;
    ifReq = 1'b0; ifAddr = '0;
    busy = 0; ifV = 1'b0; ifI = '0; dmPend = 1'b0; dmDue = 0;
    dmErrE = 1'b0; dmLoadE = 1'b0; dmDataE = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!dmReq && $urandom_range(0, 9) < 3) begin
        dmReq = 1'b1;
        dmWe  = 1'($urandom_range(0, 1));
        hi    = $urandom_range(0, 255);
        lo    = $urandom_range(0, 63);
        dmAddr = 18'(hi * 1024 + lo);
        dmW   = {4'($urandom), 32'($urandom)};
      end
      if (!ifReq && $urandom_range(0, 1) == 1) begin
        ifReq  = 1'b1;
        hi     = $urandom_range(0, 255);
        lo     = $urandom_range(0, 63);
        ifAddr = 18'(hi * 1024 + lo);
      end
      applyStimulus(ifReq, ifAddr, dmReq, dmWe, dmAddr, dmW);

      expDmV = dmPend && (dmDue == cyc);
      expI   = ifV ? ifI : heldInstr;
      expR   = (expDmV && dmLoadE) ? dmDataE : heldRdata;
      checkAll($sformatf("rnd%0d", cyc), (busy == 0) && !dmReq, busy == 0, ifV, expI,
               expDmV, expR, expDmV && dmErrE);

      if (ifV) heldInstr = ifI;
      if (expDmV) begin
        if (dmLoadE) heldRdata = dmDataE;
        dmPend = 1'b0;
      end
      ifV = 1'b0;
      if (busy > 0) begin
        busy--;
      end else if (dmReq) begin
        lo = int'(dmAddr % 18'd1024);
        a  = lo - (lo % 2);
        dmErrE  = (lo % 2) == 1;
        dmLoadE = !dmWe;
        if (!dmWe) begin
          dmDataE = {mdl[a+1], mdl[a]};
        end else if (!dmErrE) begin
          mdl[a]   = dmW[17:0];
          mdl[a+1] = dmW[35:18];
        end
        dmPend = 1'b1;
        dmDue  = cyc + 2;
        busy   = 1;
        dmReq  = 1'b0;
      end else if (ifReq) begin
        ifV   = 1'b1;
        ifI   = mdl[int'(ifAddr % 18'd1024)];
        ifReq = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
